// File: rtl/uriscv_pkg.sv
// Shared encodings for the uriscv issue stage and ALU: op codes and operand selects.
package uriscv_pkg;

    typedef enum logic [3:0] {
        RV_ALU_ADD  = 4'd0,
        RV_ALU_SUB  = 4'd1,
        RV_ALU_AND  = 4'd2,
        RV_ALU_OR   = 4'd3,
        RV_ALU_XOR  = 4'd4,
        RV_ALU_SLL  = 4'd5,
        RV_ALU_SRL  = 4'd6,
        RV_ALU_SRA  = 4'd7,
        RV_ALU_SLT  = 4'd8,
        RV_ALU_SLTU = 4'd9,
        RV_ALU_LUI  = 4'd10
    } rv_alu_op_e;

    localparam logic SEL_A_RS1 = 1'b0;
    localparam logic SEL_A_PC  = 1'b1;
    localparam logic SEL_B_RS2 = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NUM_RF = 32;

endpackage

// File: rtl/uriscv_regfile.sv
// 32x32 integer register file: two combinational read ports, one write port, x0 hardwired to zero.
module uriscv_regfile
    import uriscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    output logic [31:0] rd1_o,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs [NUM_RF];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_RF; i++) regs[i] <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            regs[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs[ra2_i];

endmodule

// File: rtl/uriscv_issue.sv
// Issue stage: scoreboard hazard check, writeback bypass and a single operand register feeding the ALU.
module uriscv_issue
    import uriscv_pkg::*;
#(
    parameter logic BYPASS_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [3:0]  dec_alu_op_i,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    input  logic [31:0] dec_imm_i,
    input  logic [31:0] dec_pc_i,
    input  logic        dec_sel_a_i,
    input  logic        dec_sel_b_i,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    output logic [3:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_rd_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic        flush_i
);

    logic [31:0] pending, pending_nxt;
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] rs1_val, rs2_val;
    logic        fwd1, fwd2, haz1, haz2, hazard, accept;

    uriscv_regfile u_regfile (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ra1_i  (dec_rs1_i),
        .rd1_o  (rf_rd1),
        .ra2_i  (dec_rs2_i),
        .rd2_o  (rf_rd2),
        .we_i   (wb_valid_i),
        .wa_i   (wb_rd_i),
        .wd_i   (wb_data_i)
    );

    function automatic logic wb_hits(input logic vld, input logic [4:0] wrd, input logic [4:0] src);
        return BYPASS_EN && vld && (wrd != 5'd0) && (wrd == src);
    endfunction

    // A pending source is only safe when the bypass can supply its value this cycle.
    always_comb begin
        fwd1    = wb_hits(wb_valid_i, wb_rd_i, dec_rs1_i);
        fwd2    = wb_hits(wb_valid_i, wb_rd_i, dec_rs2_i);
        rs1_val = fwd1 ? wb_data_i : rf_rd1;
        rs2_val = fwd2 ? wb_data_i : rf_rd2;
        haz1    = (dec_sel_a_i == SEL_A_RS1) && (dec_rs1_i != 5'd0) && pending[dec_rs1_i] && !fwd1;
        haz2    = (dec_sel_b_i == SEL_B_RS2) && (dec_rs2_i != 5'd0) && pending[dec_rs2_i] && !fwd2;
        hazard  = haz1 || haz2;
    end

    assign dec_ready_o = rst_ni && !hazard && (!alu_valid_o || alu_ready_i) && !flush_i;
    assign accept      = dec_valid_i && dec_ready_o;

    // Set after clear so a new producer of the same rd keeps the bit.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid_i) pending_nxt[wb_rd_i] = 1'b0;
        if (flush_i && alu_valid_o) pending_nxt[alu_rd_o] = 1'b0;
        if (accept && (dec_rd_i != 5'd0)) pending_nxt[dec_rd_i] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pending <= '0;
        else         pending <= pending_nxt;
    end

    // Operand register stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_valid_o <= 1'b0;
            alu_op_o    <= '0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            alu_rd_o    <= '0;
        end else if (flush_i) begin
            alu_valid_o <= 1'b0;
        end else if (accept) begin
            alu_valid_o <= 1'b1;
            alu_op_o    <= dec_alu_op_i;
            alu_a_o     <= (dec_sel_a_i == SEL_A_PC)  ? dec_pc_i  : rs1_val;
            alu_b_o     <= (dec_sel_b_i == SEL_B_IMM) ? dec_imm_i : rs2_val;
            alu_rd_o    <= dec_rd_i;
        end else if (alu_ready_i) begin
            alu_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uriscv_issue.sv
// Self-checking bench for uriscv_issue: directed scenarios plus randomized traffic against a behavioural model.
module tb_uriscv_issue;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        dec_valid_i, dec_ready_o;
    logic [3:0]  dec_alu_op_i;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic [31:0] dec_imm_i, dec_pc_i;
    logic        dec_sel_a_i, dec_sel_b_i;
    logic        alu_valid_o, alu_ready_i;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic [4:0]  alu_rd_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        flush_i;

    int checks = 0;
    int failures = 0;

    uriscv_issue #(.BYPASS_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_alu_op_i(dec_alu_op_i),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
        .dec_imm_i(dec_imm_i), .dec_pc_i(dec_pc_i), .dec_sel_a_i(dec_sel_a_i), .dec_sel_b_i(dec_sel_b_i),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_op_o(alu_op_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_rd_o(alu_rd_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural registers, busy set, and the one op waiting for the ALU.
    typedef struct {
        bit          v;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } held_t;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    held_t       m_held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_held = '{v: 1'b0, op: '0, a: '0, b: '0, rd: '0};
    endtask

    function automatic bit wb_to(input logic [4:0] r);
        return wb_valid_i && (r != 0) && (wb_rd_i == r);
    endfunction

    function automatic bit src_blocked(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !wb_to(r);
    endfunction

    function automatic logic [31:0] src_value(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_to(r)) return wb_data_i;
        return m_regs[r];
    endfunction

    function automatic bit model_ready();
        bit blocked;
        if (!rst_ni) return 1'b0;
        blocked = (!dec_sel_a_i && src_blocked(dec_rs1_i)) || (!dec_sel_b_i && src_blocked(dec_rs2_i));
        return !blocked && (!m_held.v || alu_ready_i) && !flush_i;
    endfunction

    task automatic compare();
        chk("dec_ready", {31'd0, dec_ready_o}, {31'd0, model_ready()});
        chk("alu_valid", {31'd0, alu_valid_o}, {31'd0, m_held.v});
        if (m_held.v) begin
            chk("alu_op", {28'd0, alu_op_o}, {28'd0, m_held.op});
            chk("alu_a", alu_a_o, m_held.a);
            chk("alu_b", alu_b_o, m_held.b);
            chk("alu_rd", {27'd0, alu_rd_o}, {27'd0, m_held.rd});
        end
    endtask

    task automatic model_update();
        bit    acc;
        held_t nh;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        acc = dec_valid_i && model_ready();
        nh = m_held;
        if (flush_i) nh.v = 1'b0;
        else if (acc) begin
            nh.v  = 1'b1;
            nh.op = dec_alu_op_i;
            nh.a  = dec_sel_a_i ? dec_pc_i : src_value(dec_rs1_i);
            nh.b  = dec_sel_b_i ? dec_imm_i : src_value(dec_rs2_i);
            nh.rd = dec_rd_i;
        end else if (alu_ready_i) nh.v = 1'b0;
        if (wb_valid_i && wb_rd_i != 0) m_regs[wb_rd_i] = wb_data_i;
        if (wb_valid_i) m_busy[wb_rd_i] = 1'b0;
        if (flush_i && m_held.v) m_busy[m_held.rd] = 1'b0;
        if (acc && dec_rd_i != 0) m_busy[dec_rd_i] = 1'b1;
        m_busy[0] = 1'b0;
        m_held = nh;
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        #1;
        compare();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        dec_valid_i = 0; dec_alu_op_i = 0; dec_rs1_i = 0; dec_rs2_i = 0; dec_rd_i = 0;
        dec_imm_i = 0; dec_pc_i = 0; dec_sel_a_i = 0; dec_sel_b_i = 0;
        alu_ready_i = 1; wb_valid_i = 0; wb_rd_i = 0; wb_data_i = 0; flush_i = 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic sa, input logic sb);
        dec_valid_i = 1; dec_alu_op_i = op; dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
        dec_imm_i = imm; dec_pc_i = 32'h100; dec_sel_a_i = sa; dec_sel_b_i = sb;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, alu_valid_o}, 32'd0);
        chk({tag, "_ready"}, {31'd0, dec_ready_o}, 32'd0);
        chk({tag, "_op"}, {28'd0, alu_op_o}, 32'd0);
        chk({tag, "_a"}, alu_a_o, 32'd0);
        chk({tag, "_b"}, alu_b_o, 32'd0);
        chk({tag, "_rd"}, {27'd0, alu_rd_o}, 32'd0);
    endtask

    initial begin
        idle();
        rst_ni = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        rst_ni = 1;
        @(negedge clk);

        // Writeback then read via immediate form
        wb_valid_i = 1; wb_rd_i = 5; wb_data_i = 32'h1234;
        step();
        idle();
        issue(4'd0, 5, 0, 1, 32'd4, 0, 1);
        step();
        idle();
        chk("d036_a", alu_a_o, 32'h1234);
        chk("d036_b", alu_b_o, 32'd4);
        chk("d036_valid", {31'd0, alu_valid_o}, 32'd1);

        // RAW stall until writeback, then bypassed accept
        issue(4'd0, 0, 0, 3, 32'd0, 0, 1);
        step();
        issue(4'd0, 3, 0, 4, 32'd8, 0, 1);
        for (int i = 0; i < 2; i++) begin
            #1 chk("d037_stall", {31'd0, dec_ready_o}, 32'd0);
            step();
        end
        wb_valid_i = 1; wb_rd_i = 3; wb_data_i = 32'hAA;
        #1 chk("d037_bypass_ready", {31'd0, dec_ready_o}, 32'd1);
        step();
        idle();
        chk("d037_a", alu_a_o, 32'hAA);

        // Backpressure holds the operand register
        step();
        issue(4'd2, 0, 0, 0, 32'h11, 0, 1);
        step();
        alu_ready_i = 0;
        issue(4'd3, 0, 0, 0, 32'h22, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("d038_ready", {31'd0, dec_ready_o}, 32'd0);
            chk("d038_b_hold", alu_b_o, 32'h11);
            chk("d038_op_hold", {28'd0, alu_op_o}, 32'd2);
            step();
        end
        alu_ready_i = 1;
        step();
        chk("d038_next_b", alu_b_o, 32'h22);
        idle();
        step();
        chk("d038_drained", {31'd0, alu_valid_o}, 32'd0);

        // x0 is never written and never busy
        wb_valid_i = 1; wb_rd_i = 0; wb_data_i = 32'hFFFF;
        step();
        idle();
        issue(4'd0, 0, 0, 0, 32'd0, 0, 0);
        #1 chk("d039_ready", {31'd0, dec_ready_o}, 32'd1);
        step();
        chk("d039_a", alu_a_o, 32'd0);
        chk("d039_b", alu_b_o, 32'd0);
        #1 chk("d039_x0_noblock", {31'd0, dec_ready_o}, 32'd1);
        step();
        idle();
        step();

        // Flush releases the killed producer's rd
        issue(4'd1, 0, 0, 7, 32'd5, 0, 1);
        step();
        idle();
        alu_ready_i = 0; flush_i = 1;
        step();
        flush_i = 0;
        chk("d040_valid", {31'd0, alu_valid_o}, 32'd0);
        issue(4'd0, 7, 0, 8, 32'd0, 0, 1);
        #1 chk("d040_ready", {31'd0, dec_ready_o}, 32'd1);
        step();
        idle();
        step();

        // Asynchronous reset in the middle of traffic
        issue(4'd0, 0, 0, 9, 32'h77, 0, 1);
        step();
        issue(4'd0, 0, 0, 10, 32'h88, 0, 1);
        wb_valid_i = 1; wb_rd_i = 2; wb_data_i = 32'h55;
        #2 rst_ni = 0;
        #1 chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1;
        idle();
        issue(4'd0, 9, 2, 11, 32'd0, 0, 0);
        #1 chk("d041_ready", {31'd0, dec_ready_o}, 32'd1);
        step();
        idle();
        chk("d041_a", alu_a_o, 32'd0);
        chk("d041_b", alu_b_o, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            dec_valid_i  = ($urandom_range(0, 3) != 0);
            dec_alu_op_i = 4'($urandom_range(0, 10));
            dec_rs1_i    = 5'($urandom_range(0, 7));
            dec_rs2_i    = 5'($urandom_range(0, 7));
            dec_rd_i     = 5'($urandom_range(0, 7));
            dec_imm_i    = $urandom;
            dec_pc_i     = $urandom;
            dec_sel_a_i  = ($urandom_range(0, 3) == 0);
            dec_sel_b_i  = ($urandom_range(0, 2) == 0);
            alu_ready_i  = ($urandom_range(0, 3) != 0);
            wb_valid_i   = ($urandom_range(0, 2) == 0);
            wb_rd_i      = 5'($urandom_range(0, 7));
            wb_data_i    = $urandom;
            flush_i      = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uriscv_issue.md
URISCV_ISSUE -- requirements
Module: uriscv_issue

Interface
REQ-001 SHALL provide parameter BYPASS_EN, default 1: 1 forwards same-cycle writeback data to operand reads; 0 stalls instead.
REQ-002 SHALL provide port clk_i, input, 1: single clock, all state on rising edge.
REQ-003 SHALL provide port rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL provide port dec_valid_i, input, 1: decoded instruction offered.
REQ-005 SHALL provide port dec_ready_o, output, 1: instruction accepted this cycle when high with dec_valid_i.
REQ-006 SHALL provide port dec_alu_op_i, input, 4: ALU operation code from the shared package.
REQ-007 SHALL provide ports dec_rs1_i, dec_rs2_i and dec_rd_i, input, 5 each: source and destination register indices.
REQ-008 SHALL provide ports dec_imm_i and dec_pc_i, input, 32 each: immediate and instruction PC.
REQ-009 SHALL provide port dec_sel_a_i, input, 1: operand A select, 0 = rs1, 1 = PC.
REQ-010 SHALL provide port dec_sel_b_i, input, 1: operand B select, 0 = rs2, 1 = immediate.
REQ-011 SHALL provide port alu_valid_o, output, 1: operand register holds a valid op.
REQ-012 SHALL provide port alu_ready_i, input, 1: ALU/execute consumes the op this cycle.
REQ-013 SHALL provide port alu_op_o, output, 4: registered op code to the ALU.
REQ-014 SHALL provide ports alu_a_o and alu_b_o, output, 32 each: registered operands.
REQ-015 SHALL provide port alu_rd_o, output, 5: registered destination index.
REQ-016 SHALL provide port wb_valid_i, input, 1: writeback strobe.
REQ-017 SHALL provide ports wb_rd_i (input, 5) and wb_data_i (input, 32): writeback target and data.
REQ-018 SHALL provide port flush_i, input, 1: kill the op held in the operand register.

Function
REQ-019 SHALL hold 32x32 registers; x0 reads 0, writes to x0 ignored.
REQ-020 SHALL write wb_data_i to wb_rd_i at the clock edge when wb_valid_i=1 and wb_rd_i!=0.
REQ-021 SHALL keep a 32-bit pending scoreboard: bit rd set on accept with rd!=0, cleared on writeback to rd; bit 0 always 0.
REQ-022 SHALL, on a same-cycle accept and writeback to the same rd, leave the pending bit set (new producer wins).
REQ-023 SHALL flag a hazard when a selected source (rs1 when sel_a=0, rs2 when sel_b=0) is nonzero and pending, unless BYPASS_EN=1 and wb_valid_i writes that register this cycle.
REQ-024 SHALL drive dec_ready_o = !hazard && (!alu_valid_o || alu_ready_i) && !flush_i.
REQ-025 SHALL, with BYPASS_EN=1, read wb_data_i for a source matching a nonzero wb_rd_i in the same cycle.
REQ-026 SHALL load the operand register one cycle after accept (latency 1), with A = rs1 value or PC and B = rs2 value or imm.
REQ-027 SHALL hold alu_* outputs stable while alu_valid_o=1 and alu_ready_i=0.
REQ-028 SHALL clear alu_valid_o after a consume with no new accept.
REQ-029 SHALL, on flush_i=1, clear alu_valid_o next edge and clear the pending bit of the flushed alu_rd_o; flush overrides accept.
REQ-030 SHALL sustain 1 op/cycle back-to-back with no hazard and alu_ready_i=1.

Reset
REQ-031 SHALL, with rst_ni low, asynchronously clear alu_valid_o, alu_op_o, alu_a_o, alu_b_o, alu_rd_o, all scoreboard bits and all registers to 0.
REQ-032 SHALL, with rst_ni low, hold dec_ready_o at 0; the first accept SHALL be possible in the first cycle after deassertion.
REQ-033 SHALL abort any in-progress op on mid-operation reset; no write from that cycle survives.

Structure
REQ-034 SHALL take the RV_ALU_* op codes and operand-select encodings from the shared package uriscv_pkg, common with the ALU.
REQ-035 SHALL instantiate one sub-module, uriscv_regfile, with 2 read ports, 1 write port and x0 handling; bypass and scoreboard SHALL stay in uriscv_issue.

Verification
REQ-036 SHALL cover: wb x5=0x1234 then issue ADD rs1=x5, imm=4, sel_b=1 -> next cycle alu_a_o=0x1234, alu_b_o=4, alu_valid_o=1.
REQ-037 SHALL cover: issue rd=x3, then issue rs1=x3 -> dec_ready_o=0 until wb x3=0xAA; BYPASS_EN=1 accepts that cycle with alu_a_o=0xAA.
REQ-038 SHALL cover: alu_ready_i=0 for 3 cycles with ops queued -> outputs stable, dec_ready_o=0, and no op lost or duplicated.
REQ-039 SHALL cover: write x0=0xFFFF then read x0 -> operand 0, and rd=x0 never blocks.
REQ-040 SHALL cover: flush_i with held op rd=x7 -> alu_valid_o=0 next cycle and a later reader of x7 is not stalled.
REQ-041 SHALL cover: rst_ni low mid-stream -> all outputs 0 immediately, scoreboard empty after release.
